run_stop_arbiter: RTL

Controller that shares one registered payload channel between two requesters under an IDLE/RUN/STOP run-control state machine. Each accepted byte is tagged with a free-running 32-bit sequence number and emitted as a `my_struct_t` beat. The block sits between the producer-side request ports and a downstream consumer. Its current state is exported as `state_t` for observation.

---
 rtl/run_stop_arbiter_if.sv | 39 +++
 rtl/run_stop_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/run_stop_arbiter_if.sv
// Shared types and the producer/consumer bundle of run_stop_arbiter.
// The master side drives the requests and downstream ready; the slave side is the arbiter.
package run_stop_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] field1;
    int         field2;
  } my_struct_t;
endpackage

interface run_stop_arbiter_if;
  import run_stop_arbiter_pkg::*;

  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_req_valid;
  logic [15:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic        o_valid;
  logic        i_ready;
  my_struct_t  o_i;
  state_t      o_h;
  logic        o_grant;

  modport master (
    output i_start, i_stop, i_req_valid, i_req_data, i_ready,
    input  o_req_ready, o_valid, o_i, o_h, o_grant
  );

  modport slave (
    input  i_start, i_stop, i_req_valid, i_req_data, i_ready,
    output o_req_ready, o_valid, o_i, o_h, o_grant
  );
endinterface

// File: rtl/run_stop_arbiter.sv
// Two-requester burst arbiter feeding a single registered output beat,
// gated by an IDLE/RUN/STOP run-control FSM; each beat carries a 32-bit sequence number.
module run_stop_arbiter
  import run_stop_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  run_stop_arbiter_if.slave bus
);

  localparam logic [3:0] BCNT_LAST = 4'(BURST_LEN - 1);

  logic [31:0] seq;
  logic [3:0]  bcnt;
  logic        free;
  logic        run_free;
  logic        accept;
  logic        other;
  logic [7:0]  sel_byte;

  always_comb begin
    free     = !bus.o_valid || bus.i_ready;
    run_free = (bus.o_h == RUN) && free;
    other    = ~bus.o_grant;
    accept   = run_free && bus.i_req_valid[bus.o_grant];
    sel_byte = bus.o_grant ? bus.i_req_data[15:8] : bus.i_req_data[7:0];
    bus.o_req_ready = {run_free && bus.o_grant, run_free && !bus.o_grant};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_h     <= IDLE;
      bus.o_valid <= 1'b0;
      bus.o_i     <= '0;
      bus.o_grant <= 1'b0;
      seq         <= '0;
      bcnt        <= '0;
    end else begin
      // Output register: load on accept, clear when consumed, hold while stalled.
      if (accept) begin
        bus.o_i     <= '{field1: sel_byte, field2: int'(seq)};
        bus.o_valid <= 1'b1;
        seq         <= seq + 32'd1;
      end else if (free) begin
        bus.o_valid <= 1'b0;
      end

      case (bus.o_h)
        IDLE: begin
          if (!bus.i_stop && bus.i_start) bus.o_h <= RUN;
        end
        RUN: begin
          if (bus.i_stop) bus.o_h <= STOP;
          // Arbitration still runs on the stop cycle so a last accept is counted.
          if (accept) begin
            if (bcnt == BCNT_LAST) begin
              if (bus.i_req_valid[other]) bus.o_grant <= other;
              bcnt <= '0;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end else if (!bus.i_req_valid[bus.o_grant] && bus.i_req_valid[other]) begin
            bus.o_grant <= other;
            bcnt        <= '0;
          end
        end
        STOP: begin
          if (free) bus.o_h <= IDLE;
        end
        default: bus.o_h <= IDLE;
      endcase
    end
  end

endmodule
